mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
Round-robin arbiter that shares the 4:1 bit-select datapath between four requesters. It owns the 2-bit select and drives it from a registered grant. The selected data bit is gated onto the shared output only while a grant is held. Sits in front of the mux datapath, replacing the free-running select stimulus with a sequenced, fair schedule.

Parameters:
MAX_HOLD, 8, maximum consecutive cycles one requester may hold a grant; legal range 1..255.
CNT_W, 8, width of the hold counter; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
clk  input  1  single system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
req  input  4  request per requester; req[i] high = requester i wants the datapath.
data  input  4  data bit per requester; data[i] belongs to requester i.
gnt  output  4  one-hot registered grant; all zero when idle.
sel  output  2  registered select index of current/last grantee, drives the mux.
busy  output  1  registered; high while in GRANT state.
y  output  1  combinational: data[sel] when busy, else 0.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high, sampled on rising edge of clk.
- Reset values: state=IDLE, gnt=4'b0000, sel=2'b00, busy=0, hold counter=0, rr pointer last=3 (so requester 0 has top priority first); y=0 follows from busy=0.
- States: IDLE, GRANT.
- IDLE: if req==0, stay; gnt=0, busy=0, sel holds last value.
- IDLE with req!=0: winner = first i with req[i]=1 searching last+1, last+2, last+3, last (mod 4). At the edge: state<=GRANT, gnt<=onehot(winner), sel<=winner, busy<=1, cnt<=1, last<=winner.
- Grant latency: req sampled high in cycle t -> gnt/busy high in cycle t+1.
- GRANT, release condition: req[sel]==0 OR cnt==MAX_HOLD. On release at the edge: state<=IDLE, gnt<=0, busy<=0, cnt<=0; sel and last keep the released index.
- GRANT, no release: cnt<=cnt+1; gnt and sel unchanged. Changes on other req bits are ignored.
- Every grant is followed by exactly one IDLE cycle before the next grant; no back-to-back grants.
- Hold length: a continuously requesting grantee holds exactly MAX_HOLD cycles. If the grantee drops req in cycle k of its grant (k<MAX_HOLD), gnt is high for k cycles total.
- Fairness: after a timeout, the same requester is regranted only when no other req bit is set in the IDLE cycle.
- MAX_HOLD=1: every grant lasts one cycle and alternates with one IDLE cycle.
- y is purely combinational: busy & data[sel]. A data change during a grant appears on y in the same cycle.
- Reset mid-GRANT: at the reset edge, all state returns to reset values regardless of req. Arbitration restarts from priority 0 on the first non-reset edge.
- gnt is never multi-hot. gnt==0 exactly when busy==0.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, busy=0, sel=0, y=0 throughout; first grant after release is gnt=4'b0001.
- Single request: req=4'b0100, data=4'b0100 from cycle 0 -> cycle 1 gnt=4'b0100, sel=2, y=1; drop req at cycle 4 -> cycle 5 gnt=0, busy=0.
- Round robin: req=4'b1111 held, MAX_HOLD=8 -> grants 0,1,2,3,0 in order; each gnt high 8 cycles, separated by 1 IDLE cycle.
- Timeout with sole requester: only req[3]=1, MAX_HOLD=8 -> gnt=4'b1000 for 8 cycles, 1 IDLE cycle, then regranted to 3.
- Datapath: grant to 1 with data toggling 1011 -> 1001 mid-grant -> y follows data[1] (1 then 0) the same cycle; y=0 in IDLE cycles.
- Reset mid-grant: grant to 2 at cnt=3, assert rst 1 cycle with req=4'b1100 -> next cycle IDLE, then gnt=4'b0100 (priority restarts at 0, first set bit is 2).

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter owning the 4:1 bit-select datapath
// Registered one-hot grant with bounded hold and one mandatory idle cycle between grants.
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] data,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       y
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       last;
  logic [1:0]       winner;
  logic [1:0]       cand;
  logic             found;
  logic             rel;

  // Search starts just after the last grantee, so the last grantee is checked last.
  always_comb begin
    found  = 1'b0;
    winner = last;
    cand   = last;
    for (int k = 1; k <= 4; k++) begin
      cand = last + k[1:0];
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign rel = !req[sel] || (cnt == CNT_W'(MAX_HOLD));
  assign y   = busy & data[sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      sel   <= 2'b00;
      busy  <= 1'b0;
      cnt   <= '0;
      last  <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state <= GRANT;
            gnt   <= 4'b0001 << winner;
            sel   <= winner;
            busy  <= 1'b1;
            cnt   <= CNT_W'(1);
            last  <= winner;
          end
        end
        GRANT: begin
          if (rel) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 4'b0000;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - self-checking bench for mux_rr_arbiter
// Directed scenarios plus randomized traffic against an abstract grant-schedule model.
module tb_mux_rr_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] data;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       y;

  int checks = 0;
  int errors = 0;

  // abstract model: who owns the datapath and for how many cycles so far
  bit m_valid = 0;
  bit m_busy;
  int m_owner;
  int m_held;
  int m_last;

  logic [3:0] s_gnt;
  logic [1:0] s_sel;
  logic       s_busy;
  logic       s_y;

  mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .data (data),
    .gnt  (gnt),
    .sel  (sel),
    .busy (busy),
    .y    (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [3:0] r, input logic rs);
    int c;
    if (rs) begin
      m_valid = 1;
      m_busy  = 0;
      m_owner = 0;
      m_held  = 0;
      m_last  = 3;
    end else if (m_valid) begin
      if (!m_busy) begin
        for (int k = 1; k <= 4; k++) begin
          c = (m_last + k) % 4;
          if (!m_busy && r[c]) begin
            m_busy  = 1;
            m_owner = c;
            m_last  = c;
            m_held  = 1;
          end
        end
      end else if (!r[m_owner] || m_held == MAX_HOLD) begin
        m_busy = 0;
        m_held = 0;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic cycle(input logic [3:0] r, input logic [3:0] d, input logic rs);
    logic [3:0] eg;
    @(negedge clk);
    req  = r;
    data = d;
    rst  = rs;
    #1;
    s_gnt  = gnt;
    s_sel  = sel;
    s_busy = busy;
    s_y    = y;
    if (m_valid) begin
      eg = m_busy ? (4'b0001 << m_owner) : 4'b0000;
      chk("model_gnt", s_gnt, eg);
      chk("model_sel", {2'b00, s_sel}, 4'(m_owner));
      chk("model_busy", {3'b000, s_busy}, {3'b000, m_busy});
      chk("model_y", {3'b000, s_y}, {3'b000, (m_busy ? d[m_owner] : 1'b0)});
    end
    @(posedge clk);
    model_edge(r, rs);
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] d;
    req  = 4'b0000;
    data = 4'b0000;
    rst  = 1'b1;

    // reset held with all requests pending
    cycle(4'b1111, 4'b1111, 1'b1);
    cycle(4'b1111, 4'b1111, 1'b1);
    chk("reset_gnt", s_gnt, 4'b0000);
    chk("reset_sel", {2'b00, s_sel}, 4'd0);
    chk("reset_busy", {3'b000, s_busy}, 4'd0);
    chk("reset_y", {3'b000, s_y}, 4'd0);
    cycle(4'b1111, 4'b1111, 1'b0);
    chk("post_reset_idle", s_gnt, 4'b0000);

    // round robin with everyone requesting: 8-cycle grants, 1 idle between, order 0,1,2,3,0
    for (int j = 0; j < 45; j++) begin
      cycle(4'b1111, 4'b0101, 1'b0);
      chk("rr_sched", s_gnt, ((j % 9) < 8) ? (4'b0001 << ((j / 9) % 4)) : 4'b0000);
    end

    // single request, dropped after four granted cycles
    cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b0100, 4'b0100, 1'b0);
    cycle(4'b0100, 4'b0100, 1'b0);
    chk("single_gnt", s_gnt, 4'b0100);
    chk("single_sel", {2'b00, s_sel}, 4'd2);
    chk("single_y", {3'b000, s_y}, 4'd1);
    cycle(4'b0100, 4'b0100, 1'b0);
    cycle(4'b0100, 4'b0100, 1'b0);
    cycle(4'b0000, 4'b0100, 1'b0);
    chk("single_still_held", s_gnt, 4'b0100);
    cycle(4'b0000, 4'b0100, 1'b0);
    chk("single_release_gnt", s_gnt, 4'b0000);
    chk("single_release_busy", {3'b000, s_busy}, 4'd0);
    chk("single_release_sel", {2'b00, s_sel}, 4'd2);

    // sole requester times out, sits one idle cycle, then is regranted
    cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b1000, 4'b0000, 1'b0);
    for (int j = 1; j <= 10; j++) begin
      cycle(4'b1000, 4'b0000, 1'b0);
      chk("timeout_sched", s_gnt, (j == 9) ? 4'b0000 : 4'b1000);
    end

    // y tracks data of the grantee within the same cycle
    cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b0010, 4'b1011, 1'b0);
    chk("dp_idle_y", {3'b000, s_y}, 4'd0);
    cycle(4'b0010, 4'b1011, 1'b0);
    chk("dp_gnt", s_gnt, 4'b0010);
    chk("dp_y_hi", {3'b000, s_y}, 4'd1);
    cycle(4'b0010, 4'b1001, 1'b0);
    chk("dp_y_lo", {3'b000, s_y}, 4'd0);

    // reset in the middle of a grant restarts priority from requester 0
    cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b0100, 4'b0000, 1'b0);
    cycle(4'b0100, 4'b0000, 1'b0);
    cycle(4'b0100, 4'b0000, 1'b0);
    cycle(4'b1100, 4'b0000, 1'b1);
    chk("midrst_before", s_gnt, 4'b0100);
    cycle(4'b1100, 4'b0000, 1'b0);
    chk("midrst_idle", s_gnt, 4'b0000);
    cycle(4'b1100, 4'b0000, 1'b0);
    chk("midrst_regrant", s_gnt, 4'b0100);

    // randomized traffic against the model
    for (int j = 0; j < 600; j++) begin
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'b0000;
      d = 4'($urandom_range(0, 15));
      cycle(r, d, ($urandom_range(0, 59) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
